fp_register_file_sb: RTL and testbench
======================================

// Module: fp_register_file_sb
// PURPOSE
//  Parametrised FP register file with an integrated issue scoreboard and fcsr (frm/fflags) state.
//  - Supports FLEN=32 or FLEN=64 with NaN-boxing of single-precision values.
//  - N read ports cover rs1/rs2/rs3, so FMA issues in one cycle.
//  - M write ports: FP load return plus one or more FPU pipes.
//  Sits between FP decode/issue and FPU writeback; replaces the single-write-port FP register file.
// PARAMETERS
//  FLEN          32  data width; legal values 32 or 64
//  NUM_REGS      32  register count; addresses are $clog2(NUM_REGS) bits wide (AW)
//  NUM_RD_PORTS  3   read ports
//  NUM_WR_PORTS  2   write ports; port 0 = load return, ports 1.. = FPU pipes
//  BYPASS        1   1: a same-cycle write is forwarded to reads; 0: reads see stored value only
// PORTS
//  clk            in   1                 clock, all state updates on rising edge
//  rst            in   1                 asynchronous reset, active-high
//  rd_addr[p]     in   AW                read address, per read port
//  rd_sp[p]       in   1                 read as single precision (NaN-box check; FLEN=64 only)
//  rd_data[p]     out  FLEN              read data, combinational
//  rd_busy[p]     out  1                 source register has a pending producer
//  iss_valid      in   1                 instruction with FP destination issues this cycle
//  iss_rd         in   AW                destination claimed by the issuing instruction
//  iss_waw        out  1                 iss_valid & busy[iss_rd]; issue must stall, no claim made
//  wr_en[w]       in   1                 write enable, per write port
//  wr_addr[w]     in   AW                write address
//  wr_data[w]     in   FLEN              write data
//  wr_sp[w]       in   1                 write is single precision (NaN-box on write)
//  wr_flags_en[w] in   1                 accumulate wr_flags into fflags
//  wr_flags[w]    in   5                 {NV,DZ,OF,UF,NX} from the completing operation
//  frm_wen        in   1                 CSR write of frm
//  frm_wdata      in   3                 new rounding mode
//  fflags_wen     in   1                 CSR write of fflags
//  fflags_wdata   in   5                 new fflags value
//  frm            out  3                 current rounding mode, registered
//  fflags         out  5                 current sticky flags, registered
//  wr_conflict    out  1                 registered one-cycle pulse on a same-address multi-port write
// BEHAVIOUR
//  Reset (async, rst=1): all registers, the busy vector, frm, fflags and wr_conflict are cleared to 0.
//   - Pending claims are discarded.
//   - Any writes presented in the reset-release cycle take effect normally.
//  Write (one-cycle latency): register updates at the edge after wr_en.
//   - Same address on several ports in one cycle: the highest-index port wins.
//   - That collision pulses wr_conflict=1 in the next cycle.
//  NaN-box write: with FLEN=64 and wr_sp=1, the stored value is {32'hFFFF_FFFF, wr_data[31:0]}.
//   - With FLEN=32, wr_sp and rd_sp are ignored.
//  Read (combinational, zero latency): with BYPASS=1, a matching wr_en in the same cycle forwards the winning wr_data.
//   - The forwarded value is NaN-boxed if that write has wr_sp=1.
//  NaN-box read: with FLEN=64 and rd_sp=1, if bits[63:32] are not all 1s, rd_data=64'hFFFF_FFFF_7FC0_0000.
//   - Otherwise the value is returned unchanged.
//  Scoreboard, busy[NUM_REGS]:
//   - Set: at the edge after iss_valid & ~iss_waw, busy[iss_rd] is set.
//   - Clear: any wr_en to a register clears its busy bit at that edge.
//   - Same-cycle set and clear of one register: set wins (the new producer owns it).
//   - rd_busy[p] = busy[rd_addr[p]] & ~(BYPASS & same-cycle write to rd_addr[p]).
//   - A write to a register that is not busy is legal (loads may skip the claim) and leaves busy=0.
//  frm: frm <= frm_wdata on frm_wen, otherwise it holds its value.
//  fflags: acc = OR of wr_flags[w] over all ports with wr_flags_en[w]=1, gated by wr_en[w] (each port's flags count only when that port writes).
//   - fflags_wen=1: next fflags = fflags_wdata | acc.
//   - Otherwise: next fflags = fflags | acc (sticky; never cleared except by CSR write or reset).
//  No internal FSM beyond the registered state above; there is no backpressure on write ports.
// TESTING
//  1. Reset with rst=1 mid-claim (busy[5]=1) -> rd_data=0, busy all 0, frm=0, fflags=0, wr_conflict=0.
//  2. Issue iss_rd=3, next cycle read x3 -> rd_busy=1.
//     - Then wr_en[1] addr 3 data 32'h4049_0FDB with BYPASS=1 -> rd_data=32'h4049_0FDB and rd_busy=0 in the same cycle.
//     - busy[3]=0 after the edge.
//  3. FLEN=64: write sp 32'h3F80_0000 to x1 -> read sp gives 64'hFFFF_FFFF_3F80_0000.
//     - Write dp 64'h4000_0000_0000_0000 to x2, then read x2 as sp -> 64'hFFFF_FFFF_7FC0_0000.
//  4. wr_en[0]/[1] both addr 7 (data A/B) -> x7=B, wr_conflict=1 for exactly one cycle.
//  5. fflags=5'b00001.
//     - Flags 5'b10000 on port 1 -> fflags=5'b10001.
//     - Then fflags_wen with wdata 0 and same-cycle flags 5'b00100 -> fflags=5'b00100.
//  6. busy[9]=1; iss_valid iss_rd=9 -> iss_waw=1, no claim.
//     - Same-cycle write and new claim of x9 (busy clear) -> busy[9]=1 after the edge.

Source files
------------

// File: rtl/fp_register_file_sb.sv
// Floating-point register file with an issue scoreboard and the frm/fflags state.
// Reads are combinational and can optionally forward same-cycle writes. With FLEN=64,
// single-precision values are NaN-boxed when written and checked when read.
// The per-port buses are flattened; port k occupies slice [k*W +: W].
module fp_register_file_sb #(
  parameter int FLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 3,
  parameter int NUM_WR_PORTS = 2,
  parameter bit BYPASS       = 1'b1,
  parameter int AW           = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD_PORTS*AW-1:0]     rd_addr_i,
  input  logic [NUM_RD_PORTS-1:0]        rd_sp_i,
  output logic [NUM_RD_PORTS*FLEN-1:0]   rd_data_o,
  output logic [NUM_RD_PORTS-1:0]        rd_busy_o,
  input  logic                           iss_valid_i,
  input  logic [AW-1:0]                  iss_rd_i,
  output logic                           iss_waw_o,
  input  logic [NUM_WR_PORTS-1:0]        wr_en_i,
  input  logic [NUM_WR_PORTS*AW-1:0]     wr_addr_i,
  input  logic [NUM_WR_PORTS*FLEN-1:0]   wr_data_i,
  input  logic [NUM_WR_PORTS-1:0]        wr_sp_i,
  input  logic [NUM_WR_PORTS-1:0]        wr_flags_en_i,
  input  logic [NUM_WR_PORTS*5-1:0]      wr_flags_i,
  input  logic                           frm_wen_i,
  input  logic [2:0]                     frm_wdata_i,
  input  logic                           fflags_wen_i,
  input  logic [4:0]                     fflags_wdata_i,
  output logic [2:0]                     frm_o,
  output logic [4:0]                     fflags_o,
  output logic                           wr_conflict_o
);

  // Upper-half ones mask: the NaN-box pattern for FLEN=64, and zero for FLEN=32,
  // so boxing and the box check both reduce to no-ops at single width.
  localparam logic [FLEN-1:0] UPPER_ONES   = {FLEN{1'b1}} << 32;
  localparam logic [63:0]     CANON_NAN_64 = 64'hFFFF_FFFF_7FC0_0000;
  localparam logic [FLEN-1:0] CANON_NAN    = CANON_NAN_64[FLEN-1:0];
  localparam bit              IS_DP        = (FLEN == 64);

  logic [FLEN-1:0]     regs_q [NUM_REGS];
  logic [FLEN-1:0]     regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [2:0]          frm_q, frm_d;
  logic [4:0]          fflags_q, fflags_d;
  logic [4:0]          flags_acc;
  logic                wr_conflict_q, wr_conflict_d;
  logic                iss_waw;
  logic [AW-1:0]       wr_a   [NUM_WR_PORTS];
  logic [FLEN-1:0]     wr_val [NUM_WR_PORTS];

  // A claim is refused while the destination still has an outstanding producer.
  assign iss_waw       = iss_valid_i & busy_q[iss_rd_i];
  assign iss_waw_o     = iss_waw;
  assign frm_o         = frm_q;
  assign fflags_o      = fflags_q;
  assign wr_conflict_o = wr_conflict_q;

  // Unpack the write ports and apply NaN-boxing to single-precision writes.
  always_comb begin
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      wr_a[w]   = wr_addr_i[w*AW +: AW];
      wr_val[w] = wr_data_i[w*FLEN +: FLEN];
      if (IS_DP && wr_sp_i[w]) wr_val[w] = wr_val[w] | UPPER_ONES;
    end
  end

  // Next register and busy state. Ports are visited in ascending order, so the
  // highest-index writer wins. The claim is applied last, so it wins over a
  // same-cycle clear.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) regs_d[r] = regs_q[r];
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      if (wr_en_i[w]) begin
        regs_d[wr_a[w]] = wr_val[w];
        busy_d[wr_a[w]] = 1'b0;
      end
    end
    if (iss_valid_i && !iss_waw) busy_d[iss_rd_i] = 1'b1;
  end

  // Flag any pair of ports that write the same address in one cycle.
  always_comb begin
    wr_conflict_d = 1'b0;
    for (int i = 0; i < NUM_WR_PORTS; i++) begin
      for (int j = i + 1; j < NUM_WR_PORTS; j++) begin
        if (wr_en_i[i] && wr_en_i[j] && (wr_a[i] == wr_a[j])) wr_conflict_d = 1'b1;
      end
    end
  end

  // Exception flags are accumulated only from ports that actually write. A CSR
  // write replaces the sticky value but still merges the flags from that cycle.
  always_comb begin
    flags_acc = '0;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      if (wr_en_i[w] && wr_flags_en_i[w]) flags_acc = flags_acc | wr_flags_i[w*5 +: 5];
    end
    fflags_d = fflags_wen_i ? (fflags_wdata_i | flags_acc) : (fflags_q | flags_acc);
    frm_d    = frm_wen_i ? frm_wdata_i : frm_q;
  end

  // Combinational read path: stored value, optional same-cycle forward, then the
  // NaN-box check for single-precision reads.
  always_comb begin
    logic [AW-1:0]   rd_a;
    logic [FLEN-1:0] rd_val;
    logic            rd_hit;
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_a   = rd_addr_i[p*AW +: AW];
      rd_val = regs_q[rd_a];
      rd_hit = 1'b0;
      if (BYPASS) begin
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
          if (wr_en_i[w] && (wr_a[w] == rd_a)) begin
            rd_val = wr_val[w];
            rd_hit = 1'b1;
          end
        end
      end
      if (IS_DP && rd_sp_i[p] && ((rd_val & UPPER_ONES) != UPPER_ONES)) rd_val = CANON_NAN;
      rd_data_o[p*FLEN +: FLEN] = rd_val;
      rd_busy_o[p]              = busy_q[rd_a] & ~rd_hit;
    end
  end

  // State registers. An asynchronous reset drops every pending claim.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      busy_q        <= '0;
      frm_q         <= '0;
      fflags_q      <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
      busy_q        <= busy_d;
      frm_q         <= frm_d;
      fflags_q      <= fflags_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

endmodule

// File: tb/tb_fp_register_file_sb.sv
// Self-checking bench for fp_register_file_sb (FLEN=64, 3 read / 2 write ports, bypass on).
module tb_fp_register_file_sb;
  localparam int FLEN = 64;
  localparam int NRD  = 3;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD-1:0]       rd_sp;
  logic [NRD*FLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rd;
  logic                 iss_waw;
  logic [NWR-1:0]       wr_en, wr_sp, wr_flags_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*FLEN-1:0]  wr_data;
  logic [NWR*5-1:0]     wr_flags;
  logic                 frm_wen, fflags_wen;
  logic [2:0]           frm_wdata, frm;
  logic [4:0]           fflags_wdata, fflags;
  logic                 wr_conflict;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_exp  [$];
  string       sb_name [$];

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
    logic        wsp;
    logic        rsp;
    logic [63:0] exp;
  } vec_t;
  vec_t vec [7];

  fp_register_file_sb #(
    .FLEN(FLEN), .NUM_REGS(32), .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR), .BYPASS(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr_i(rd_addr), .rd_sp_i(rd_sp), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .iss_waw_o(iss_waw),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_sp_i(wr_sp),
    .wr_flags_en_i(wr_flags_en), .wr_flags_i(wr_flags),
    .frm_wen_i(frm_wen), .frm_wdata_i(frm_wdata),
    .fflags_wen_i(fflags_wen), .fflags_wdata_i(fflags_wdata),
    .frm_o(frm), .fflags_o(fflags), .wr_conflict_o(wr_conflict)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_push(string nm, logic [63:0] e);
    sb_name.push_back(nm);
    sb_exp.push_back(e);
  endtask

  task automatic sb_pop(logic [63:0] act);
    if (sb_exp.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got %h expected none", act);
    end else begin
      chk(sb_name.pop_front(), act, sb_exp.pop_front());
    end
  endtask

  task automatic idle();
    rd_addr = '0; rd_sp = '0; iss_valid = 1'b0; iss_rd = '0;
    wr_en = '0; wr_sp = '0; wr_addr = '0; wr_data = '0;
    wr_flags_en = '0; wr_flags = '0;
    frm_wen = 1'b0; frm_wdata = '0; fflags_wen = 1'b0; fflags_wdata = '0;
  endtask

  // Inputs change 1 ns after the rising edge; checks run at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_wr(int w, logic [4:0] a, logic [63:0] d, logic sp);
    wr_en[w] = 1'b1;
    wr_addr[w*AW +: AW] = a;
    wr_data[w*FLEN +: FLEN] = d;
    wr_sp[w] = sp;
  endtask

  task automatic drv_rd(int p, logic [4:0] a, logic sp);
    rd_addr[p*AW +: AW] = a;
    rd_sp[p] = sp;
  endtask

  function automatic logic [63:0] rdd(int p);
    return rd_data[p*FLEN +: FLEN];
  endfunction

  initial begin
    logic busy_any;
    vec[0] = '{5'd1,  64'h0000_0000_3F80_0000, 1'b1, 1'b1, 64'hFFFF_FFFF_3F80_0000};
    vec[1] = '{5'd2,  64'h4000_0000_0000_0000, 1'b0, 1'b1, 64'hFFFF_FFFF_7FC0_0000};
    vec[2] = '{5'd10, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 64'h4000_0000_0000_0000};
    vec[3] = '{5'd11, 64'hFFFF_FFFF_1234_5678, 1'b0, 1'b1, 64'hFFFF_FFFF_1234_5678};
    vec[4] = '{5'd12, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0, 64'hFFFF_FFFF_CAFE_F00D};
    vec[5] = '{5'd0,  64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF};
    vec[6] = '{5'd31, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1, 64'hFFFF_FFFF_7FC0_0000};

    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Test 1: reset with a claim on x5 outstanding and other state non-zero.
    iss_valid = 1'b1; iss_rd = 5'd5;
    drv_wr(0, 5'd4, 64'h0000_0000_0000_ABCD, 1'b0);
    drv_wr(1, 5'd4, 64'h1234_5678_9ABC_DEF0, 1'b0);
    frm_wen = 1'b1; frm_wdata = 3'd5;
    fflags_wen = 1'b1; fflags_wdata = 5'b00011;
    step();
    idle();
    drv_rd(0, 5'd5, 1'b0);
    drv_rd(1, 5'd4, 1'b0);
    #1;
    chk("pre_rst_busy_x5", rd_busy[0], 1'b1);
    chk("pre_rst_x4", rdd(1), 64'h1234_5678_9ABC_DEF0);
    chk("pre_rst_frm", frm, 3'd5);
    chk("pre_rst_fflags", fflags, 5'b00011);
    chk("pre_rst_conflict", wr_conflict, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_x4", rdd(1), 64'h0);
    chk("rst_frm", frm, 3'd0);
    chk("rst_fflags", fflags, 5'd0);
    chk("rst_conflict", wr_conflict, 1'b0);
    busy_any = 1'b0;
    for (int a = 0; a < 32; a++) begin
      drv_rd(2, 5'(a), 1'b0);
      #1;
      busy_any = busy_any | rd_busy[2];
    end
    chk("rst_busy_all", busy_any, 1'b0);
    step();
    rst = 1'b0;

    // Table-driven write/read vectors, including NaN-box write and read cases.
    for (int i = 0; i < 7; i++) begin
      step();
      idle();
      drv_wr(i % 2, vec[i].addr, vec[i].data, vec[i].wsp);
      step();
      idle();
      drv_rd(i % 3, vec[i].addr, vec[i].rsp);
      sb_push($sformatf("vec%0d_rd", i), vec[i].exp);
      #4;
      sb_pop(rdd(i % 3));
      chk($sformatf("vec%0d_busy", i), rd_busy[i % 3], 1'b0);
    end

    // Test 2: claim x3, then forward the producer's write in the same cycle.
    step();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd3;
    step();
    idle();
    drv_rd(1, 5'd3, 1'b1);
    #4;
    chk("t2_busy_set", rd_busy[1], 1'b1);
    step();
    idle();
    drv_rd(1, 5'd3, 1'b1);
    drv_rd(2, 5'd3, 1'b0);
    drv_wr(1, 5'd3, 64'h0000_0000_4049_0FDB, 1'b1);
    sb_push("t2_bypass_sp", 64'hFFFF_FFFF_4049_0FDB);
    sb_push("t2_bypass_dp", 64'hFFFF_FFFF_4049_0FDB);
    #4;
    sb_pop(rdd(1));
    sb_pop(rdd(2));
    chk("t2_bypass_busy", rd_busy[1], 1'b0);
    step();
    idle();
    drv_rd(1, 5'd3, 1'b1);
    sb_push("t2_stored", 64'hFFFF_FFFF_4049_0FDB);
    #4;
    sb_pop(rdd(1));
    chk("t2_busy_cleared", rd_busy[1], 1'b0);

    // Test 4: collision on x7, then a non-colliding dual write.
    step();
    idle();
    drv_wr(0, 5'd7, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    drv_wr(1, 5'd7, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0);
    drv_rd(0, 5'd7, 1'b0);
    sb_push("t4_fwd_winner", 64'hBBBB_BBBB_BBBB_BBBB);
    #4;
    sb_pop(rdd(0));
    chk("t4_conflict_pre", wr_conflict, 1'b0);
    step();
    idle();
    drv_rd(0, 5'd7, 1'b0);
    sb_push("t4_stored_winner", 64'hBBBB_BBBB_BBBB_BBBB);
    #4;
    sb_pop(rdd(0));
    chk("t4_conflict_pulse", wr_conflict, 1'b1);
    step();
    idle();
    drv_wr(0, 5'd13, 64'h1313_1313_1313_1313, 1'b0);
    drv_wr(1, 5'd14, 64'h1414_1414_1414_1414, 1'b0);
    #4;
    chk("t4_conflict_one_cycle", wr_conflict, 1'b0);
    step();
    idle();
    drv_rd(0, 5'd13, 1'b0);
    drv_rd(1, 5'd14, 1'b0);
    sb_push("t4_x13", 64'h1313_1313_1313_1313);
    sb_push("t4_x14", 64'h1414_1414_1414_1414);
    #4;
    sb_pop(rdd(0));
    sb_pop(rdd(1));
    chk("t4_no_conflict", wr_conflict, 1'b0);

    // Test 5: fflags sticky accumulation, write gating, and CSR overwrite; frm hold.
    step();
    idle();
    fflags_wen = 1'b1; fflags_wdata = 5'b00001;
    step();
    idle();
    chk("t5_fflags_csr", fflags, 5'b00001);
    wr_flags_en[1] = 1'b1; wr_flags[9:5] = 5'b01000;
    step();
    idle();
    chk("t5_flags_gated", fflags, 5'b00001);
    drv_wr(1, 5'd20, 64'h0, 1'b0);
    wr_flags_en[1] = 1'b1; wr_flags[9:5] = 5'b10000;
    step();
    idle();
    chk("t5_fflags_acc", fflags, 5'b10001);
    fflags_wen = 1'b1; fflags_wdata = 5'b00000;
    drv_wr(0, 5'd21, 64'h0, 1'b0);
    wr_flags_en[0] = 1'b1; wr_flags[4:0] = 5'b00100;
    step();
    idle();
    chk("t5_fflags_csr_merge", fflags, 5'b00100);
    frm_wen = 1'b1; frm_wdata = 3'd3;
    step();
    idle();
    chk("t5_fflags_hold", fflags, 5'b00100);
    chk("t5_frm_write", frm, 3'd3);
    step();
    chk("t5_frm_hold", frm, 3'd3);

    // Test 6: WAW stall makes no claim; same-cycle clear and new claim keeps busy.
    idle();
    iss_valid = 1'b1; iss_rd = 5'd9;
    #4;
    chk("t6_waw_free", iss_waw, 1'b0);
    step();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd9;
    drv_wr(0, 5'd9, 64'h9999_0000_0000_0001, 1'b0);
    drv_rd(0, 5'd9, 1'b0);
    #4;
    chk("t6_waw_stall", iss_waw, 1'b1);
    chk("t6_bypass_busy", rd_busy[0], 1'b0);
    step();
    idle();
    drv_rd(0, 5'd9, 1'b0);
    #4;
    chk("t6_no_claim", rd_busy[0], 1'b0);
    step();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd9;
    drv_wr(1, 5'd9, 64'h9999_0000_0000_0002, 1'b0);
    #4;
    chk("t6_waw_clear", iss_waw, 1'b0);
    step();
    idle();
    drv_rd(0, 5'd9, 1'b0);
    sb_push("t6_x9", 64'h9999_0000_0000_0002);
    #4;
    sb_pop(rdd(0));
    chk("t6_set_wins", rd_busy[0], 1'b1);

    if (sb_exp.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d expected 0", sb_exp.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
